// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: next-PC select codes,
// FSM state encoding, NOP word and default vectors.
package if_stage_pkg;

    typedef logic [2:0] pc_src_t;

    localparam pc_src_t SRC_PC4    = 3'd0;
    localparam pc_src_t SRC_BRANCH = 3'd1;
    localparam pc_src_t SRC_JUMP   = 3'd2;
    localparam pc_src_t SRC_JR     = 3'd3;
    localparam pc_src_t SRC_IRQ    = 3'd4;
    localparam pc_src_t SRC_EXC    = 3'd5;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_PC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_PC   = 32'h8000_0008;

    function automatic logic [31:0] jump_addr(input logic [31:0] pc, input logic [25:0] idx);
        return {pc[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus plus IF/ID outputs of the fetch stage.
// master = fetch stage, slave = memory / decode side.
interface if_stage_if;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_overflow;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;

    modport master (
        output rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, fetch_fault,
        input  rom_data, rom_overflow
    );

    modport slave (
        input  rom_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, fetch_fault,
        output rom_data, rom_overflow
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
// A bubble still records the PC so later stages can attribute it.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
        end else if (bubble) begin
            if_id_pc    <= pc;
            if_id_pc4   <= pc + 32'd4;
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_pc    <= pc;
            if_id_pc4   <= pc + 32'd4;
            if_id_instr <= instr;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, BOOT/RUN/FAULT FSM.
// Build option BRANCH_DELAY_SLOT_EN keeps the word after a taken branch/jump/jr.
//
// state | meaning
// BOOT  | after reset: one bubble, PC held
// RUN   | normal fetch
// FAULT | fetch fault: pulse fetch_fault, bubble, PC <= EXC_PC
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IRQ_PC   = DEF_IRQ_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  pc_src_t     pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    if_stage_if.master  bus
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    logic [31:0] pc, pc_next, pc_seq, jr_eff;
    logic [1:0]  state, state_next;
    logic        ifid_load, ifid_bubble, redirect, vector;
    logic [31:0] q_pc, q_pc4, q_instr;
    logic        q_valid;

    // User mode may not jump into supervisor space through jr.
    assign jr_eff   = {pc[31] & jr_target[31], jr_target[30:0]};
    assign redirect = (pc_src == SRC_BRANCH) || (pc_src == SRC_JUMP) || (pc_src == SRC_JR);
    assign vector   = (pc_src == SRC_IRQ) || (pc_src == SRC_EXC);

    always_comb begin
        case (pc_src)
            SRC_BRANCH: pc_seq = branch_target;
            SRC_JUMP:   pc_seq = jump_addr(pc, jump_index);
            SRC_JR:     pc_seq = jr_eff;
            SRC_IRQ:    pc_seq = IRQ_PC;
            SRC_EXC:    pc_seq = EXC_PC;
            default:    pc_seq = pc + 32'd4;
        endcase
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state)
            ST_BOOT: begin
                ifid_bubble = 1'b1;
                state_next  = ST_RUN;
            end
            ST_FAULT: begin
                ifid_bubble = 1'b1;
                pc_next     = (pc_src == SRC_IRQ) ? IRQ_PC : EXC_PC;
                state_next  = ST_RUN;
            end
            default: begin
                if (vector) begin
                    ifid_bubble = 1'b1;
                    pc_next     = pc_seq;
                end else if (bus.rom_overflow && !stall) begin
                    ifid_bubble = 1'b1;
                    state_next  = ST_FAULT;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    pc_next     = stall ? pc : pc_seq;
                end else if (!stall) begin
                    pc_next = pc_seq;
                    if (redirect && !DELAY_SLOT) ifid_bubble = 1'b1;
                    else                         ifid_load   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= ST_BOOT;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .pc          (pc),
        .instr       (bus.rom_data),
        .if_id_pc    (q_pc),
        .if_id_pc4   (q_pc4),
        .if_id_instr (q_instr),
        .if_id_valid (q_valid)
    );

    assign bus.rom_addr    = pc[30:0];
    assign bus.if_id_pc    = q_pc;
    assign bus.if_id_pc4   = q_pc4;
    assign bus.if_id_instr = q_instr;
    assign bus.if_id_valid = q_valid;
    assign bus.fetch_fault = (state == ST_FAULT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: driver pushes hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_if_stage;
    import if_stage_pkg::*;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    typedef struct packed {
        logic [30:0] rom_addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    pc_src_t     pc_src = 3'd0;
    logic [31:0] branch_target = 32'h0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] jr_target = 32'h0;

    if_stage_if bus ();

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic exp_t ex(logic [30:0] rom, logic [31:0] p, logic [31:0] p4,
                                logic [31:0] ins, logic v, logic f);
        exp_t e;
        e.rom_addr = rom; e.pc = p; e.pc4 = p4; e.instr = ins; e.valid = v; e.fault = f;
        return e;
    endfunction

    // Entry latched on a taken branch/jump/jr: kept only with delay slots.
    function automatic exp_t ds(logic [30:0] rom, logic [31:0] p, logic [31:0] d);
        return ex(rom, p, p + 32'd4, DS ? d : 32'h0, DS, 1'b0);
    endfunction

    task automatic step(input logic rn, input logic st, input logic fl, input pc_src_t src,
                        input logic [31:0] tgt, input logic [31:0] data, input logic ovf,
                        input exp_t e);
        rst_n            = rn;
        stall            = st;
        flush            = fl;
        pc_src           = src;
        branch_target    = tgt;
        jr_target        = tgt;
        jump_index       = tgt[25:0];
        bus.rom_data     = data;
        bus.rom_overflow = ovf;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = ex(bus.rom_addr, bus.if_id_pc, bus.if_id_pc4, bus.if_id_instr,
                       bus.if_id_valid, bus.fetch_fault);
                n_vec++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL vec%0d: got rom=%h pc=%h pc4=%h instr=%h v=%b f=%b, expected rom=%h pc=%h pc4=%h instr=%h v=%b f=%b",
                             n_vec, a.rom_addr, a.pc, a.pc4, a.instr, a.valid, a.fault,
                             e.rom_addr, e.pc, e.pc4, e.instr, e.valid, e.fault);
                end
            end
        end
    end

    initial begin : driver
        bus.rom_data     = 32'h0;
        bus.rom_overflow = 1'b0;
        @(negedge clk);
        //   rn st fl src   tgt           data          ovf  expected after the edge
        step(0, 0, 0, 3'd0, 32'h0,        32'h3c114000, 0, ex(31'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'h3c114000, 0, ex(31'h0, 32'h8000_0000, 32'h8000_0004, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'h3c114000, 0, ex(31'h4, 32'h8000_0000, 32'h8000_0004, 32'h3c114000, 1, 0));
        step(1, 0, 0, 3'd1, 32'h10,       32'h11111111, 0, ds(31'h10, 32'h8000_0004, 32'h11111111));
        step(1, 0, 0, 3'd3, 32'h8000_0100, 32'h22222222, 0, ds(31'h100, 32'h10, 32'h22222222));
        step(1, 0, 0, 3'd0, 32'h0,        32'h33333333, 0, ex(31'h104, 32'h100, 32'h104, 32'h33333333, 1, 0));
        step(1, 0, 0, 3'd1, 32'h8000_0040, 32'h44444444, 0, ds(31'h40, 32'h104, 32'h44444444));
        step(1, 0, 0, 3'd2, 32'h15,       32'h55555555, 0, ds(31'h54, 32'h8000_0040, 32'h55555555));
        step(1, 0, 0, 3'd3, 32'h8000_0200, 32'h66666666, 0, ds(31'h200, 32'h8000_0054, 32'h66666666));
        step(1, 0, 0, 3'd1, 32'h80,       32'h77777777, 0, ds(31'h80, 32'h8000_0200, 32'h77777777));
        // fetch fault at 0x80
        step(1, 0, 0, 3'd0, 32'h0,        32'hdeadbeef, 1, ex(31'h80, 32'h80, 32'h84, 32'h0, 0, 1));
        step(1, 0, 0, 3'd0, 32'h0,        32'h12345678, 0, ex(31'h8, 32'h80, 32'h84, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'haaaa0001, 0, ex(31'hc, 32'h8000_0008, 32'h8000_000c, 32'haaaa0001, 1, 0));
        // stall with irq on its second cycle
        step(1, 1, 0, 3'd0, 32'h0,        32'hbbbb0000, 0, ex(31'hc, 32'h8000_0008, 32'h8000_000c, 32'haaaa0001, 1, 0));
        step(1, 1, 0, 3'd4, 32'h0,        32'hbbbb0001, 0, ex(31'h4, 32'h8000_000c, 32'h8000_0010, 32'h0, 0, 0));
        step(1, 1, 0, 3'd0, 32'h0,        32'hbbbb0002, 0, ex(31'h4, 32'h8000_000c, 32'h8000_0010, 32'h0, 0, 0));
        step(1, 1, 0, 3'd0, 32'h0,        32'hbbbb0003, 1, ex(31'h4, 32'h8000_000c, 32'h8000_0010, 32'h0, 0, 0));
        step(1, 0, 1, 3'd0, 32'h0,        32'hcccc0000, 0, ex(31'h8, 32'h8000_0004, 32'h8000_0008, 32'h0, 0, 0));
        step(1, 1, 1, 3'd0, 32'h0,        32'hcccc0001, 0, ex(31'h8, 32'h8000_0008, 32'h8000_000c, 32'h0, 0, 0));
        step(1, 0, 0, 3'd5, 32'h0,        32'hcccc0002, 1, ex(31'h8, 32'h8000_0008, 32'h8000_000c, 32'h0, 0, 0));
        // PC wrap
        step(1, 0, 0, 3'd1, 32'hFFFF_FFFC, 32'h0d0d0d0d, 0, ds(31'h7FFF_FFFC, 32'h8000_0008, 32'h0d0d0d0d));
        step(1, 0, 0, 3'd0, 32'h0,        32'h0e0e0e0e, 0, ex(31'h0, 32'hFFFF_FFFC, 32'h0, 32'h0e0e0e0e, 1, 0));
        // reset mid-FAULT, then reset mid-stall
        step(1, 0, 0, 3'd0, 32'h0,        32'h0f0f0f0f, 1, ex(31'h0, 32'h0, 32'h4, 32'h0, 0, 1));
        step(0, 0, 0, 3'd0, 32'h0,        32'h0f0f0f0f, 1, ex(31'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'hf0f0f0f0, 0, ex(31'h0, 32'h8000_0000, 32'h8000_0004, 32'h0, 0, 0));
        step(1, 1, 0, 3'd0, 32'h0,        32'hf0f0f0f1, 0, ex(31'h0, 32'h8000_0000, 32'h8000_0004, 32'h0, 0, 0));
        step(0, 1, 0, 3'd0, 32'h0,        32'hf0f0f0f2, 0, ex(31'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'h3c114000, 0, ex(31'h0, 32'h8000_0000, 32'h8000_0004, 32'h0, 0, 0));
        step(1, 0, 0, 3'd0, 32'h0,        32'h3c114000, 0, ex(31'h4, 32'h8000_0000, 32'h8000_0004, 32'h3c114000, 1, 0));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
